// File: rtl/vga_bitmap_screen.sv
// ---------------------------------------------------------------------------
// vga_bitmap_screen
//
// Full-screen VGA bitmap renderer. Generates SVGA-style timing, fetches a
// monochrome bitmap one row at a time from an external synchronous ROM
// (1-clock latency), and places it at (X0, Y0) with optional 2^SCALE_LOG2
// upscaling. Foreground and background colours and the image enable are
// latched once per frame. Optional blinking hides the image for
// BLINK_FRAMES frames out of every 2*BLINK_FRAMES.
//
// Pipeline: S0 counters -> S1 rom_addr/col/control -> S2 rom_data valid ->
// S3 output registers. Every VGA output appears 3 clocks after the counter
// state that produced it.
//
// Ports
//   CLK_40M      in   pixel clock
//   RST          in   asynchronous reset, active-high
//   img_en       in   1 = draw image, 0 = background only (frame-latched)
//   blink_en     in   1 = blink the image
//   fg_color     in   {r,g,b} for bitmap bits equal to 1 (frame-latched)
//   bg_color     in   {r,g,b} for bitmap bits equal to 0 / outside image
//   rom_addr     out  bitmap row index
//   rom_data     in   bitmap row, bit IMG_W-1 = leftmost pixel
//   vga_hsync    out  horizontal sync
//   vga_vsync    out  vertical sync
//   vga_red/green/blue out colour bits (000 during blanking)
//   vga_de       out  active-video flag, aligned with colours
//   frame_start  out  one-clock pulse with the first active pixel of a frame
// ---------------------------------------------------------------------------
module vga_bitmap_screen #(
    parameter int H_ACTIVE     = 800,
    parameter int H_FP         = 40,
    parameter int H_SYNC       = 128,
    parameter int H_BP         = 88,
    parameter int V_ACTIVE     = 600,
    parameter int V_FP         = 1,
    parameter int V_SYNC       = 4,
    parameter int V_BP         = 23,
    parameter bit SYNC_POL     = 1'b1,
    parameter int IMG_W        = 256,
    parameter int IMG_H        = 256,
    parameter int ROM_AW       = 8,
    parameter int X0           = 272,
    parameter int Y0           = 172,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              CLK_40M,
    input  logic              RST,
    input  logic              img_en,
    input  logic              blink_en,
    input  logic [2:0]        fg_color,
    input  logic [2:0]        bg_color,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [IMG_W-1:0]  rom_data,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_red,
    output logic              vga_green,
    output logic              vga_blue,
    output logic              vga_de,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // All window/sync bounds as 32-bit unsigned so comparisons need no
    // per-parameter width juggling.
    localparam logic [31:0] H_ACT_U  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_U  = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] X0_U     = 32'(X0);
    localparam logic [31:0] Y0_U     = 32'(Y0);
    localparam logic [31:0] X_END    = 32'(X0 + (IMG_W << SCALE_LOG2));
    localparam logic [31:0] Y_END    = 32'(Y0 + (IMG_H << SCALE_LOG2));

    // Control bits that travel alongside a pixel through the pipeline.
    // Sync fields hold "asserted", polarity is applied at the output.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic win;
    } ctrl_t;

    // -----------------------------------------------------------------------
    // S0: timing counters
    // -----------------------------------------------------------------------
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic          frame_wrap;
    logic          at_origin;

    assign h_last     = (h == HW'(H_TOTAL - 1));
    assign v_last     = (v == VW'(V_TOTAL - 1));
    assign frame_wrap = h_last & v_last;
    assign at_origin  = (h == '0) && (v == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of
    // block ordering.
    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            if (v_last) v <= '0;
            else        v <= v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Frame-latched shadows and blink state
    // -----------------------------------------------------------------------
    logic [2:0] fg_sh;
    logic [2:0] bg_sh;
    logic       img_en_sh;
    logic [7:0] blink_cnt;
    logic       blink_phase;

    // Shadows load while the counters sit at (0,0). The first pixel of the
    // frame reaches S3 two edges later, so it already sees the new values,
    // while the pixels still in flight from the previous frame are blanking.
    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            fg_sh     <= 3'b000;
            bg_sh     <= 3'b000;
            img_en_sh <= 1'b0;
        end else if (at_origin) begin
            fg_sh     <= fg_color;
            bg_sh     <= bg_color;
            img_en_sh <= img_en;
        end
    end

    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S0 decode: region flags, source column and row
    // -----------------------------------------------------------------------
    logic [31:0]       h32;
    logic [31:0]       v32;
    ctrl_t             c0;
    logic [CW-1:0]     col0;
    logic [ROM_AW-1:0] row0;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        h32    = 32'(h);
        v32    = 32'(v);
        c0     = '0;
        c0.de  = (h32 < H_ACT_U) && (v32 < V_ACT_U);
        c0.hs  = (h32 >= HS_START) && (h32 < HS_END);
        c0.vs  = (v32 >= VS_START) && (v32 < VS_END);
        c0.fs  = at_origin;
        // Gating with de clips a window that runs off the visible area.
        c0.win = c0.de && (h32 >= X0_U) && (h32 < X_END)
                       && (v32 >= Y0_U) && (v32 < Y_END);
        // Offsets wrap outside the window; they are only consumed inside it.
        col0   = CW'((h32 - X0_U) >> SCALE_LOG2);
        row0   = ROM_AW'((v32 - Y0_U) >> SCALE_LOG2);
    end

    // -----------------------------------------------------------------------
    // S1: ROM address, column, control
    // -----------------------------------------------------------------------
    ctrl_t         c1;
    logic [CW-1:0] col1;

    // NOTE: every pipeline stage is reset, so a reset mid-frame flushes the
    // pipe and nothing half-processed emerges after release.
    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            c1       <= '0;
            col1     <= '0;
            rom_addr <= '0;
        end else begin
            c1   <= c0;
            col1 <= col0;
            // Outside the window the address holds, so the ROM stays quiet.
            if (c0.win) rom_addr <= row0;
        end
    end

    // -----------------------------------------------------------------------
    // S2: ROM data valid this stage; carry column and control alongside it
    // -----------------------------------------------------------------------
    ctrl_t         c2;
    logic [CW-1:0] col2;

    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            c2   <= '0;
            col2 <= '0;
        end else begin
            c2   <= c1;
            col2 <= col1;
        end
    end

    // -----------------------------------------------------------------------
    // S3: pixel select and output registers
    // -----------------------------------------------------------------------
    logic [CW-1:0] bit_idx;
    logic          pixel_bit;
    logic          show_img;
    logic [2:0]    colour_nxt;

    always_comb begin
        // Column 0 is the MSB of the row word.
        bit_idx    = CW'(IMG_W - 1) - col2;
        pixel_bit  = rom_data[bit_idx];
        // Gating with blink_en directly hides the image only while blinking
        // is on, even before the phase register has been cleared.
        show_img   = img_en_sh & ~(blink_en & blink_phase);
        colour_nxt = 3'b000;
        if (c2.de) begin
            if (c2.win && show_img && pixel_bit) colour_nxt = fg_sh;
            else                                 colour_nxt = bg_sh;
        end
    end

    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            vga_red     <= 1'b0;
            vga_green   <= 1'b0;
            vga_blue    <= 1'b0;
        end else begin
            vga_hsync   <= c2.hs ? SYNC_POL : ~SYNC_POL;
            vga_vsync   <= c2.vs ? SYNC_POL : ~SYNC_POL;
            vga_de      <= c2.de;
            frame_start <= c2.fs;
            {vga_red, vga_green, vga_blue} <= colour_nxt;
        end
    end

endmodule

// File: tb/tb_vga_bitmap_screen.sv
// ---------------------------------------------------------------------------
// tb_vga_bitmap_screen
//
// Three instances share one clock and reset:
//   u_a : small timing (48x35 totals, 40x30 active), 16x16 image at (10,5),
//         BLINK_FRAMES = 2 -- pixels, syncs, shadowing, blink, mid-frame reset
//   u_b : same timing, SCALE_LOG2 = 1 at (0,0) -- 2x2 upscale and rom_addr
//   u_c : default parameters -- line timing (1056 clocks, hsync at 840)
// Position p is the linear counter index whose outputs are visible at the
// negedge after edge p+3 since reset release.
// ---------------------------------------------------------------------------
module tb_vga_bitmap_screen;

    localparam int HT = 48;     // 40 + 2 + 4 + 2
    localparam int FR = 1680;   // 48 * 35

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic img_en   = 1'b1;
    logic blink_en = 1'b1;
    logic [2:0] fg = 3'b111;
    logic [2:0] bg = 3'b001;

    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic [3:0]  rom_addr_a;
    logic [15:0] rom_data_a;
    logic hs_a, vs_a, r_a, g_a, b_a, de_a, fs_a;

    vga_bitmap_screen #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(30), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .IMG_W(16), .IMG_H(16), .ROM_AW(4),
        .X0(10), .Y0(5), .SCALE_LOG2(0), .BLINK_FRAMES(2)
    ) u_a (
        .CLK_40M(clk), .RST(rst), .img_en(img_en), .blink_en(blink_en),
        .fg_color(fg), .bg_color(bg), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_red(r_a), .vga_green(g_a),
        .vga_blue(b_a), .vga_de(de_a), .frame_start(fs_a)
    );

    // ---------------- instance B ----------------
    logic [3:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic hs_b, vs_b, r_b, g_b, b_b, de_b, fs_b;

    vga_bitmap_screen #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(30), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .IMG_W(16), .IMG_H(16), .ROM_AW(4),
        .X0(0), .Y0(0), .SCALE_LOG2(1), .BLINK_FRAMES(2)
    ) u_b (
        .CLK_40M(clk), .RST(rst), .img_en(img_en), .blink_en(blink_en),
        .fg_color(fg), .bg_color(bg), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_red(r_b), .vga_green(g_b),
        .vga_blue(b_b), .vga_de(de_b), .frame_start(fs_b)
    );

    // ---------------- instance C (defaults) ----------------
    logic [7:0]   rom_addr_c;
    logic [255:0] rom_data_c = '0;
    logic hs_c, vs_c, r_c, g_c, b_c, de_c, fs_c;

    vga_bitmap_screen u_c (
        .CLK_40M(clk), .RST(rst), .img_en(img_en), .blink_en(blink_en),
        .fg_color(fg), .bg_color(bg), .rom_addr(rom_addr_c), .rom_data(rom_data_c),
        .vga_hsync(hs_c), .vga_vsync(vs_c), .vga_red(r_c), .vga_green(g_c),
        .vga_blue(b_c), .vga_de(de_c), .frame_start(fs_c)
    );

    // ROM content: row r = {r, ~r} twice (e.g. row 3 = 0011_1100 0011_1100).
    function automatic logic [15:0] row_bits(input logic [3:0] r);
        return {2{r, ~r}};
    endfunction

    always @(posedge clk) begin
        rom_data_a <= row_bits(rom_addr_a);
        rom_data_b <= row_bits(rom_addr_b);
    end

    // ---------------- bookkeeping ----------------
    int cyc;
    int fs_cnt_a;
    int de_cnt_a;
    int de_cnt_c;
    int checks   = 0;
    int failures = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            fs_cnt_a <= 0;
            de_cnt_a <= 0;
            de_cnt_c <= 0;
        end else begin
            if (fs_a) fs_cnt_a <= fs_cnt_a + 1;
            if (de_a && (cyc - 3) < FR) de_cnt_a <= de_cnt_a + 1;
            if (de_c) de_cnt_c <= de_cnt_c + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the negedge where the outputs of position p are visible.
    task automatic wait_pos(input int p);
        int guard = 0;
        while ((cyc - 3) < p && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if ((cyc - 3) != p) check("position_reached", 32'(cyc - 3), 32'(p));
    endtask

    function automatic int pa(input int f, input int x, input int y);
        return f * FR + y * HT + x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (5) @(negedge clk);
        check("rst_de_a",    de_a, 0);
        check("rst_col_a",   {r_a, g_a, b_a}, 3'b000);
        check("rst_hs_a",    hs_a, 0);
        check("rst_vs_a",    vs_a, 0);
        check("rst_fs_a",    fs_a, 0);
        check("rst_addr_a",  rom_addr_a, 0);
        check("rst_hs_c",    hs_c, 0);
        check("rst_col_c",   {r_c, g_c, b_c}, 3'b000);
        check("rst_addr_c",  rom_addr_c, 0);
        rst = 1'b0;

        // ---------------- latency and frame 0 ----------------
        wait_pos(-1);
        check("fill_de_a", de_a, 0);
        wait_pos(0);
        check("first_de_a",  de_a, 1);
        check("first_fs_a",  fs_a, 1);
        check("first_col_a", {r_a, g_a, b_a}, 3'b001);
        check("first_fs_c",  fs_c, 1);
        check("first_de_c",  de_c, 1);
        wait_pos(1);   check("fs_one_clk_a", fs_a, 0);
        wait_pos(39);  check("de_last_a", de_a, 1);
        wait_pos(40);  check("de_off_a", de_a, 0);
                       check("blank_col_a", {r_a, g_a, b_a}, 3'b000);
        wait_pos(41);  check("hs_pre_a", hs_a, 0);
        wait_pos(42);  check("hs_start_a", hs_a, 1);
        wait_pos(45);  check("hs_end_a", hs_a, 1);
        wait_pos(46);  check("hs_post_a", hs_a, 0);

        // B: row 2 (v=4), scaled column 15 at x=30..31, clipped at 32
        wait_pos(pa(0, 31, 4)); check("b_col15", {r_b, g_b, b_b}, 3'b111);
        wait_pos(pa(0, 32, 4)); check("b_clip",  {r_b, g_b, b_b}, 3'b001);

        // A: row 0 = 0000_1111
        wait_pos(pa(0, 13, 5)); check("a_r0_c3", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 14, 5)); check("a_r0_c4", {r_a, g_a, b_a}, 3'b111);

        // B: row 3 = 0011_1100, 2x2 pixels
        wait_pos(pa(0, 4, 6));  check("b_c2", {r_b, g_b, b_b}, 3'b111);
                                check("b_addr", rom_addr_b, 3);
        wait_pos(pa(0, 6, 6));  check("b_c3", {r_b, g_b, b_b}, 3'b111);
        wait_pos(pa(0, 8, 6));  check("b_c4", {r_b, g_b, b_b}, 3'b111);
        wait_pos(pa(0, 12, 6)); check("b_c6", {r_b, g_b, b_b}, 3'b001);
        wait_pos(pa(0, 5, 7));  check("b_c2_dup", {r_b, g_b, b_b}, 3'b111);

        // A: row 3 = 0011_1100 0011_1100 at v=8
        wait_pos(pa(0, 9, 8));  check("a_left_out", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 10, 8)); check("a_c0",  {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 12, 8)); check("a_c2",  {r_a, g_a, b_a}, 3'b111);
                                check("a_addr_r3", rom_addr_a, 3);
        wait_pos(pa(0, 15, 8)); check("a_c5",  {r_a, g_a, b_a}, 3'b111);
        wait_pos(pa(0, 16, 8)); check("a_c6",  {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 20, 8)); check("a_c10", {r_a, g_a, b_a}, 3'b111);
        wait_pos(pa(0, 25, 8)); check("a_c15", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 26, 8)); check("a_right_out", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 40, 8)); check("a_addr_hold", rom_addr_a, 3);

        // Mid-frame colour change: must not show until frame 1
        wait_pos(pa(0, 0, 15)); fg = 3'b100;

        // C: default line timing
        wait_pos(799);  check("c_de_799", de_c, 1);
        wait_pos(800);  check("c_de_800", de_c, 0);
        wait_pos(839);  check("c_hs_839", hs_c, 0);
        wait_pos(840);  check("c_hs_840", hs_c, 1);
        wait_pos(967);  check("c_hs_967", hs_c, 1);
        wait_pos(968);  check("c_hs_968", hs_c, 0);

        wait_pos(pa(0, 12, 20)); check("a_r15_fg_old", {r_a, g_a, b_a}, 3'b111);
        wait_pos(1000); check("c_de_per_line", de_cnt_c, 800);
        wait_pos(pa(0, 12, 21)); check("a_bottom_out", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(0, 20, 21)); check("a_addr_r15", rom_addr_a, 15);
        wait_pos(1056); check("c_line1_de", de_c, 1);

        wait_pos(pa(0, 0, 30)); check("a_vs_30", vs_a, 0);
        wait_pos(pa(0, 0, 31)); check("a_vs_31", vs_a, 1);
        wait_pos(pa(0, 5, 31)); check("a_de_per_frame", de_cnt_a, 1200);
        wait_pos(pa(0, 0, 32)); check("a_vs_32", vs_a, 1);
        wait_pos(pa(0, 0, 33)); check("a_vs_33", vs_a, 0);

        // ---------------- frames 1..6: shadowing and blink ----------------
        wait_pos(pa(1, 0, 0));  check("f1_fs", fs_a, 1);
        wait_pos(pa(1, 12, 8)); check("f1_fg_new", {r_a, g_a, b_a}, 3'b100);
        wait_pos(pa(2, 12, 8)); check("f2_blink_off", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(3, 12, 8)); check("f3_blink_off", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(4, 0, 0));  check("f4_fs", fs_a, 1);
        wait_pos(pa(4, 12, 8)); check("f4_blink_on", {r_a, g_a, b_a}, 3'b100);
        wait_pos(pa(4, 0, 20)); img_en = 1'b0;
        wait_pos(pa(4, 12, 20)); check("f4_img_en_shadow", {r_a, g_a, b_a}, 3'b100);
        wait_pos(pa(5, 12, 8)); check("f5_img_off", {r_a, g_a, b_a}, 3'b001);
        wait_pos(pa(5, 0, 20)); img_en = 1'b1; blink_en = 1'b0;
        wait_pos(pa(6, 5, 0));  check("fs_count", fs_cnt_a, 7);
        wait_pos(pa(6, 12, 8)); check("f6_blink_dis", {r_a, g_a, b_a}, 3'b100);

        // ---------------- mid-frame reset ----------------
        wait_pos(pa(6, 20, 15));
        rst = 1'b1;
        #1;
        check("mrst_de",   de_a, 0);
        check("mrst_col",  {r_a, g_a, b_a}, 3'b000);
        check("mrst_hs",   hs_a, 0);
        check("mrst_fs",   fs_a, 0);
        check("mrst_addr", rom_addr_a, 0);
        check("mrst_de_c", de_c, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_pos(-1);  check("mrst_fill_de", de_a, 0);
        wait_pos(0);   check("mrst_first_de", de_a, 1);
                       check("mrst_first_fs", fs_a, 1);
        wait_pos(pa(0, 12, 8)); check("mrst_pixel", {r_a, g_a, b_a}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_bitmap_screen.md
# vga_bitmap_screen

Parametrised full-screen VGA bitmap renderer. It generates SVGA timing, fetches a monochrome bitmap one row at a time from an external synchronous ROM, and places it at a configurable position with optional integer upscaling, frame-latched foreground and background colours, and optional blinking. It is the generic replacement for the fixed-size per-screen display tops (game-over, title and similar) and drives the 1-bit-per-channel VGA pins directly.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porch and sync lengths in clocks
- V_ACTIVE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porch and sync lengths in lines
- SYNC_POL, 1, sync level while asserted (1 = positive pulse)
- IMG_W / IMG_H, 256 / 256, bitmap size in source pixels
- ROM_AW, 8, ROM address width; must satisfy 2^ROM_AW >= IMG_H
- X0 / Y0, 272 / 172, top-left screen coordinate of the displayed image
- SCALE_LOG2, 0, upscale factor 2^SCALE_LOG2 (0..2)
- BLINK_FRAMES, 30, frames per blink half-period (1..255)
- CLK_40M  in  1  pixel clock
- RST  in  1  asynchronous reset, active-high
- img_en  in  1  1 = draw image, 0 = background only
- blink_en  in  1  1 = blink the image
- fg_color  in  3  {r,g,b} for bitmap bits equal to 1
- bg_color  in  3  {r,g,b} for bitmap bits equal to 0 and for active area outside the image
- rom_addr  out  ROM_AW  bitmap row index
- rom_data  in  IMG_W  bitmap row; bit IMG_W-1 is the leftmost pixel; valid 1 clock after rom_addr
- vga_hsync / vga_vsync  out  1  sync outputs
- vga_red / vga_green / vga_blue  out  1  colour outputs
- vga_de  out  1  active-video flag, aligned with colour outputs
- frame_start  out  1  one-clock pulse aligned with the first active pixel of each frame

## Operation
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise. h wraps to 0 at H_TOTAL-1; v increments on that wrap and itself wraps at V_TOTAL-1.
- Active when h < H_ACTIVE and v < V_ACTIVE. Hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on v.
- Image window: X0 <= h < X0+(IMG_W<<SCALE_LOG2), Y0 <= v < Y0+(IMG_H<<SCALE_LOG2). Window clipped to the active area when it overruns the screen.
- Inside the window: col = (h-X0)>>SCALE_LOG2, row = (v-Y0)>>SCALE_LOG2. rom_addr = row, zero-extended. Outside the window rom_addr holds its last value.
- Pixel bit = rom_data[IMG_W-1-col]. Colour = fg when the bit is 1, otherwise bg. Active area outside the window shows bg. Blanking drives colour 000 and vga_de = 0.
- Colour shadowing: fg_color, bg_color and img_en are latched into shadow registers at h = 0, v = 0 only. Changes mid-frame take effect on the next frame; there is no tearing.
- Blink: an 8-bit frame counter and a phase bit. Each time v wraps, the counter increments. On reaching BLINK_FRAMES-1 the counter clears and the phase toggles. When blink_en = 1 and phase = 1, the image is hidden and bg is shown. When blink_en = 0, the phase is forced to 0 and the counter clears.
- The image is hidden (bg only) when shadowed img_en = 0.

## Timing
- Three-stage pipeline:
  - S0: counters.
  - S1: rom_addr, col and control registered.
  - S2: rom_data valid.
  - S3: output registers.
- All outputs (syncs, de, colours, frame_start) appear exactly 3 clocks after the counter state that produced them. Syncs and de are delayed through matching shift registers.
- frame_start is high for exactly one clock per frame, coincident with the first vga_de = 1 of that frame.
- Reset: counters 0, phase 0, frame counter 0, shadows 0, rom_addr 0, colours 000, vga_de 0, frame_start 0, syncs at !SYNC_POL.
- Reset release: the first sync, de and colour outputs derived from counter (0,0) appear 3 clocks after the first active edge.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. No partial pipeline contents emerge after release.
- ROM latency is fixed at 1 clock. No handshake; rom_data is sampled unconditionally in S2.

## Test plan
- Default parameters, reset for 5 clocks, run 2 frames -> H_TOTAL = 1056, V_TOTAL = 628; hsync high for 128 clocks starting 840 clocks after line start; vsync high for 4 lines; 480000 de-cycles per frame.
- ROM model with row r = {r[7:0] replicated 32 times}, fg = 111, bg = 001 -> pixel (272+8k+j, 172+r) shows 111 iff bit 7-j of r is 1; pixel (271,172) shows 001; rom_addr = r during row r.
- SCALE_LOG2 = 1, X0 = Y0 = 0 -> each source pixel covers 2x2 screen pixels; the image is clipped at column 512 (still inside 800); rom_addr = v>>1.
- Change fg_color from 111 to 100 at line 300 of frame 0 -> frame 0 shows 111 throughout; frame 1 shows 100 throughout.
- blink_en = 1, BLINK_FRAMES = 2 -> image visible in frames 0-1, hidden in frames 2-3, visible in frames 4-5; frame_start pulses once per frame.
- Assert RST at h = 400, v = 300 -> all outputs take reset values immediately; after release the timing restarts from (0,0) with 3-clock latency.
